// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-side definitions: data width, default FIFO geometry and
// capture FSM state encodings (same encodings are used on the TX side).
package uart_rx_fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } rx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port feeding the first-word-fall-through head.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; contents are only observed once written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: rdy/rdy_clr capture handshake into a FWFT FIFO with
// sticky overrun. Optional almost_full comparator via UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    parameter int AF_LEVEL = 12
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_rdy_clr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              almost_full
);

    localparam int CW = ADDR_W + 1;

    rx_state_e         state_q, state_d;
    logic              rx_rdy_clr_q, rx_rdy_clr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              cap_s, wr_s, rd_s, drop_s;

    // Capture/read qualification; at full a same-edge pop makes room for the byte.
    always_comb begin
        cap_s  = (state_q == ST_IDLE) && rx_rdy;
        rd_s   = rd_en && !empty_q;
        wr_s   = cap_s && (!full_q || rd_en);
        drop_s = cap_s && full_q && !rd_en;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; WAIT_LOW keeps a held rdy from being captured twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_rdy) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!rx_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: rdy_clr is registered, so it follows the ACK cycle by one edge.
    always_comb begin
        rx_rdy_clr_d = (state_q == ST_ACK);
    end

    // Pointer, occupancy and overrun next-state.
    always_comb begin
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_rdy_clr_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_rdy_clr_q <= rx_rdy_clr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_s),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef UART_RX_FIFO_AFULL_EN
    logic almost_full_q, almost_full_d;

    // Threshold on next-state count so the flag moves on the same edge as count.
    always_comb begin
        almost_full_d = (count_d >= CW'(AF_LEVEL));
    end

    // almost_full register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`else
    assign almost_full = 1'b0;
`endif

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;
    logic       almost_full;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue, sticky overrun, handshake bookkeeping.
    logic [7:0] mq[$];
    bit         m_ovr;
    bit         byte_taken;
    int         age;

    typedef struct {
        logic       r;
        logic [7:0] d;
        logic       re;
        logic       oc;
        int         cnt;
        logic       clr;
        logic [7:0] head;
    } vec_t;

    vec_t tbl[5];

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .rx_rdy_clr  (rx_rdy_clr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit exp_af();
`ifdef UART_RX_FIFO_AFULL_EN
        return (mq.size() >= AF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, " rx_rdy_clr"}, 32'(rx_rdy_clr), 32'(age == 2));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(exp_af()));
        if (mq.size() > 0) chk({tag, " rd_data"}, 32'(rd_data), 32'(mq[0]));
    endtask

    // One clock: apply inputs, advance the model by the rules, compare after the edge.
    task automatic step(input logic r, input logic [7:0] d, input logic re, input logic oc);
        bit cap, acc, drop, rdv;
        rx_rdy  = r;
        rx_data = d;
        rd_en   = re;
        ovr_clr = oc;
        cap  = r && !byte_taken;
        acc  = cap && ((mq.size() < DEPTH) || re);
        drop = cap && !acc;
        rdv  = re && (mq.size() > 0);
        if (rdv) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        if (drop) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        if (cap) begin
            byte_taken = 1'b1;
            age = 1;
        end else if (age != 0 && age < 7) begin
            age++;
        end
        if (!r) byte_taken = 1'b0;
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    // Receiver-side handshake: hold rdy until rdy_clr, then drop it for one edge.
    task automatic send_byte(input logic [7:0] d, input logic re_at_cap);
        step(1'b1, d, re_at_cap, 1'b0);
        for (int k = 0; k < 6 && !rx_rdy_clr; k++) step(1'b1, d, 1'b0, 1'b0);
        if (!rx_rdy_clr) begin
            checks++;
            errors++;
            $display("FAIL handshake: rx_rdy_clr=%0b for byte 0x%0h, required 1 within 6 cycles", rx_rdy_clr, d);
        end
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        m_ovr      = 1'b0;
        byte_taken = 1'b0;
        age        = 0;
        #2;
        check_all("reset");
        chk("reset rx_rdy_clr", 32'(rx_rdy_clr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rr;
        logic [7:0] rdat;
        logic       re;
        int         low;
        int         hi;
        int         pulses;

        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
        m_ovr = 1'b0; byte_taken = 1'b0; age = 0;
        #1;
        do_reset();

        // Single-byte handshake as a vector table.
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].re, tbl[i].oc);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d rx_rdy_clr", i), 32'(rx_rdy_clr), 32'(tbl[i].clr));
            if (tbl[i].cnt > 0) chk($sformatf("vec%0d head", i), 32'(rd_data), 32'(tbl[i].head));
            if (rx_rdy_clr) pulses++;
        end
        chk("single pulse", 32'(pulses), 32'd1);

        // Fill to full, then overflow by one.
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        chk("fill count", 32'(count), 32'd16);
        chk("fill full", 32'(full), 32'd1);
        send_byte(8'hFF, 1'b0);
        chk("drop overrun", 32'(overrun), 32'd1);
        chk("drop head", 32'(rd_data), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Write and read on the same edge while full.
        send_byte(8'h10, 1'b1);
        chk("full wr+rd count", 32'(count), 32'd16);
        chk("full wr+rd overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("last entry", 32'(rd_data), 32'h10);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained empty", 32'(empty), 32'd1);

        // Wrap-around with entries in flight.
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3), 1'b1);
        while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

        // almost_full threshold.
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(8'h50 + i), 1'b0);
            if (i == 10) chk("af at 11", 32'(almost_full), 32'd0);
        end
`ifdef UART_RX_FIFO_AFULL_EN
        chk("af at 12", 32'(almost_full), 32'd1);
`else
        chk("af at 12", 32'(almost_full), 32'd0);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("af back to 11", 32'(almost_full), 32'd0);
        while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset during the handshake; the pending byte is taken again afterwards.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("pre-reset clr", 32'(rx_rdy_clr), 32'd1);
        do_reset();
        send_byte(8'h5A, 1'b0);
        chk("recapture count", 32'(count), 32'd1);
        chk("recapture head", 32'(rd_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with varying read pressure.
        rr = 1'b0; rdat = 8'h00; low = 1; hi = 0;
        for (int c = 0; c < 1500; c++) begin
            if (rr && rx_rdy_clr) begin
                rr = 1'b0;
            end else if (!rr && low >= 1 && $urandom_range(0, 2) == 0) begin
                rr = 1'b1;
                rdat = 8'($urandom);
            end
            case ((c / 150) % 3)
                0:       re = ($urandom_range(0, 3) == 0);
                1:       re = ($urandom_range(0, 3) != 0);
                default: re = ($urandom_range(0, 1) == 0);
            endcase
            step(rr, rdat, re, ($urandom_range(0, 15) == 0));
            if (rr) begin
                hi++;
                low = 0;
            end else begin
                low++;
                hi = 0;
            end
            if (hi > 8) begin
                checks++;
                errors++;
                $display("FAIL random handshake: rx_rdy_clr=%0b after %0d cycles, required 1", rx_rdy_clr, hi);
                rr = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
